// File: rtl/hbus_ctrl.sv
// rtl/hbus_ctrl.sv - HyperBus transaction sequencer, 4 bytes per clk_1x cycle
// Optional read idle timeout is built when HBUS_CTRL_TIMEOUT_EN is defined.

module hbus_ctrl #(
  parameter int N_CS       = 4,
  parameter int TCSH       = 2,
  parameter int RD_TIMEOUT = 64
) (
  input  logic            clk_1x,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic            cmd_write,
  input  logic            cmd_reg,
  input  logic [N_CS-1:0] cmd_cs,
  input  logic [31:0]     wr_data,
  input  logic [3:0]      wr_mask,
  output logic            wr_ack,
  output logic [31:0]     rd_data,
  output logic            rd_valid,
  output logic            rd_last,
  output logic            done,
  output logic            err,
  input  logic [3:0]      cfg_lat,
  output logic [1:0]      phy_ck_en,
  output logic [31:0]     phy_dq_out,
  output logic [1:0]      phy_dq_oe,
  output logic [3:0]      phy_rwds_out,
  output logic [1:0]      phy_rwds_oe,
  input  logic [31:0]     phy_dq_in,
  input  logic [3:0]      phy_rwds_in,
  output logic [N_CS-1:0] phy_cs_n,
  output logic            phy_rst_n
);

  typedef enum logic [2:0] {
    IDLE, CA0, CA1, LAT, WDATA, RDATA, RDRAIN, CSHI
  } state_t;

  // st names the phase whose outputs are registered at the next edge,
  // so every PHY output appears one cycle after its state is entered.
  state_t          st;
  logic [31:0]     a_addr;
  logic [8:0]      a_len;
  logic            a_write;
  logic            a_reg;
  logic [N_CS-1:0] a_cs;
  logic [3:0]      a_lat;
  logic [8:0]      cnt;
  logic [8:0]      rcnt;
  logic            cap_en;
  logic [47:0]     ca;
  logic            word_hit;
  logic            last_hit;

`ifdef HBUS_CTRL_TIMEOUT_EN
  localparam int IW = $clog2(RD_TIMEOUT + 1);
  logic [IW-1:0]   idle_cnt;
  logic            err_pend;
`endif

  assign ca       = {~a_write, a_reg, 1'b1, a_addr[31:3], 13'd0, a_addr[2:0]};
  assign word_hit = cap_en && (phy_rwds_in == 4'b0101);
  assign last_hit = word_hit && (rcnt == a_len);

  always_ff @(posedge clk_1x) begin
    if (!rst_n) begin
      st           <= IDLE;
      cmd_ready    <= 1'b0;
      wr_ack       <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      phy_ck_en    <= '0;
      phy_dq_out   <= '0;
      phy_dq_oe    <= '0;
      phy_rwds_out <= '0;
      phy_rwds_oe  <= '0;
      phy_cs_n     <= '1;
      phy_rst_n    <= 1'b0;
      a_addr       <= '0;
      a_len        <= '0;
      a_write      <= 1'b0;
      a_reg        <= 1'b0;
      a_cs         <= '0;
      a_lat        <= '0;
      cnt          <= '0;
      rcnt         <= '0;
      cap_en       <= 1'b0;
`ifdef HBUS_CTRL_TIMEOUT_EN
      idle_cnt     <= '0;
      err_pend     <= 1'b0;
`endif
    end else begin
      phy_rst_n    <= 1'b1;
      cmd_ready    <= 1'b0;
      wr_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      phy_ck_en    <= 2'b00;
      phy_dq_out   <= '0;
      phy_dq_oe    <= 2'b00;
      phy_rwds_out <= '0;
      phy_rwds_oe  <= 2'b00;
      phy_cs_n     <= '1;
      cap_en       <= 1'b0;

      if (word_hit) begin
        rd_valid <= 1'b1;
        rd_data  <= phy_dq_in;
        rcnt     <= rcnt + 9'd1;
        rd_last  <= last_hit;
      end

      case (st)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            a_addr  <= cmd_addr;
            a_len   <= {1'b0, cmd_len};
            a_write <= cmd_write;
            a_reg   <= cmd_reg;
            a_cs    <= cmd_cs;
            a_lat   <= cfg_lat;
            cnt     <= '0;
            rcnt    <= '0;
`ifdef HBUS_CTRL_TIMEOUT_EN
            idle_cnt <= '0;
            err_pend <= 1'b0;
`endif
            st      <= CA0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        CA0: begin
          phy_ck_en  <= 2'b11;
          phy_dq_oe  <= 2'b11;
          phy_cs_n   <= ~a_cs;
          phy_dq_out <= {ca[23:16], ca[31:24], ca[39:32], ca[47:40]};
          // Register-write data rides in CA1, so request it one cycle early.
          wr_ack     <= a_write && a_reg;
          st         <= CA1;
        end
        CA1: begin
          phy_ck_en  <= 2'b11;
          phy_dq_oe  <= 2'b11;
          phy_cs_n   <= ~a_cs;
          phy_dq_out <= {(a_write && a_reg) ? wr_data[15:0] : 16'h0000, ca[7:0], ca[15:8]};
          cnt        <= '0;
          st         <= (a_write && a_reg) ? CSHI : LAT;
        end
        LAT: begin
          phy_ck_en <= 2'b11;
          phy_cs_n  <= ~a_cs;
          cap_en    <= ~a_write;
          if (cnt + 9'd1 >= {5'd0, a_lat}) begin
            wr_ack <= a_write;
            cnt    <= '0;
            st     <= a_write ? WDATA : RDATA;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        WDATA: begin
          phy_ck_en    <= 2'b11;
          phy_dq_oe    <= 2'b11;
          phy_rwds_oe  <= 2'b11;
          phy_cs_n     <= ~a_cs;
          phy_dq_out   <= wr_data;
          phy_rwds_out <= wr_mask;
          wr_ack       <= (cnt < a_len);
          if (cnt == a_len) begin
            cnt <= '0;
            st  <= CSHI;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        RDATA: begin
          phy_ck_en <= 2'b11;
          phy_cs_n  <= ~a_cs;
          cap_en    <= 1'b1;
          if (cnt == a_len) begin
            st <= RDRAIN;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        RDRAIN: begin
          phy_cs_n <= ~a_cs;
          cap_en   <= 1'b1;
        end
        CSHI: begin
          done <= (cnt == 9'd0);
`ifdef HBUS_CTRL_TIMEOUT_EN
          err  <= (cnt == 9'd0) && err_pend;
`endif
          if (cnt + 9'd1 >= 9'(TCSH)) begin
            cnt <= '0;
            st  <= IDLE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: st <= IDLE;
      endcase

      // The final read word ends the burst wherever it lands.
      if (last_hit) begin
        cnt    <= '0;
        cap_en <= 1'b0;
        st     <= CSHI;
      end

`ifdef HBUS_CTRL_TIMEOUT_EN
      if (st == RDATA || st == RDRAIN) begin
        if (word_hit) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IW'(RD_TIMEOUT - 1)) begin
          cnt      <= '0;
          cap_en   <= 1'b0;
          err_pend <= 1'b1;
          st       <= CSHI;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_hbus_ctrl.sv
// tb/tb_hbus_ctrl.sv - randomized self-checking bench for hbus_ctrl
// Timeout scenario is exercised when HBUS_CTRL_TIMEOUT_EN is defined.

module tb_hbus_ctrl;
  localparam int N_CS       = 4;
  localparam int TCSH       = 2;
  localparam int RD_TIMEOUT = 64;

  logic            clk_1x;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [31:0]     cmd_addr;
  logic [7:0]      cmd_len;
  logic            cmd_write;
  logic            cmd_reg;
  logic [N_CS-1:0] cmd_cs;
  logic [31:0]     wr_data;
  logic [3:0]      wr_mask;
  logic            wr_ack;
  logic [31:0]     rd_data;
  logic            rd_valid;
  logic            rd_last;
  logic            done;
  logic            err;
  logic [3:0]      cfg_lat;
  logic [1:0]      phy_ck_en;
  logic [31:0]     phy_dq_out;
  logic [1:0]      phy_dq_oe;
  logic [3:0]      phy_rwds_out;
  logic [1:0]      phy_rwds_oe;
  logic [31:0]     phy_dq_in;
  logic [3:0]      phy_rwds_in;
  logic [N_CS-1:0] phy_cs_n;
  logic            phy_rst_n;

  hbus_ctrl #(.N_CS(N_CS), .TCSH(TCSH), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk_1x(clk_1x), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_cs(cmd_cs),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_ack(wr_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .err(err), .cfg_lat(cfg_lat),
    .phy_ck_en(phy_ck_en), .phy_dq_out(phy_dq_out), .phy_dq_oe(phy_dq_oe),
    .phy_rwds_out(phy_rwds_out), .phy_rwds_oe(phy_rwds_oe),
    .phy_dq_in(phy_dq_in), .phy_rwds_in(phy_rwds_in),
    .phy_cs_n(phy_cs_n), .phy_rst_n(phy_rst_n)
  );

  initial clk_1x = 1'b0;
  always #5 clk_1x = ~clk_1x;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] wq [256];
  logic [3:0]  mq [256];
  logic [31:0] rq [16];
  int          sq [16];
  logic [31:0] cap_ca0;
  logic [31:0] cap_ca1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic issue(input bit wr, input bit rg, input logic [31:0] addr,
                       input int len, input int lat, input logic [N_CS-1:0] cs);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 40) begin
      @(negedge clk_1x);
      w++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    cmd_write = wr;
    cmd_reg   = rg;
    cmd_cs    = cs;
    cfg_lat   = 4'(lat);
    @(posedge clk_1x);
  endtask

  // Expected timeline is derived from the command alone: offsets are cycles
  // after the accept edge, done offset D, CS# high for TCSH, then ready.
  task automatic run_txn(input bit wr, input bit rg, input logic [31:0] addr,
                         input int len, input int lat, input logic [N_CS-1:0] cs,
                         input bit tmo);
    logic [47:0]     ca;
    logic [31:0]     e0, e1;
    logic [N_CS-1:0] e_cs;
    logic [3:0]      jv;
    int d, wd_lo, wd_hi, ck_end, ack_n, ack_exp, idx, rj;
    bit in_wd, e_vld;
    ca = {~wr, rg, 1'b1, addr[31:3], 13'd0, addr[2:0]};
    for (int k = 0; k < 4; k++) e0[8*k +: 8] = ca[47-8*k -: 8];
    e1 = {(wr && rg) ? wq[0][15:0] : 16'h0000, ca[7:0], ca[15:8]};
    wd_lo = 3 + lat;
    wd_hi = 3 + lat + len;
    if (wr && rg)      d = 3;
    else if (wr)       d = 4 + lat + len;
    else if (tmo)      d = 3 + lat + RD_TIMEOUT;
    else               d = sq[len] + 2;
    if (wr && rg)      ck_end = 2;
    else if (wr)       ck_end = wd_hi;
    else               ck_end = (wd_hi < d - 1) ? wd_hi : d - 1;
    ack_exp = (wr && rg) ? 1 : (wr ? len + 1 : 0);
    ack_n = 0;
    issue(wr, rg, addr, len, lat, cs);
    for (int o = 0; o <= d + TCSH; o++) begin
      @(negedge clk_1x);
      cmd_valid = 1'b0;
      in_wd = wr && !rg && o >= wd_lo && o <= wd_hi;
      e_cs  = (o >= 1 && o < d) ? ~cs : '1;
      chk("done", 32'(done), 32'(o == d));
      chk("err", 32'(err), 32'(o == d && tmo));
      chk("cmd_ready", 32'(cmd_ready), 32'(o == d + TCSH));
      chk("cs_n", 32'(phy_cs_n), 32'(e_cs));
      chk("ck_en", 32'(phy_ck_en), (o >= 1 && o <= ck_end) ? 32'd3 : 32'd0);
      chk("dq_oe", 32'(phy_dq_oe), (o == 1 || o == 2 || in_wd) ? 32'd3 : 32'd0);
      chk("rwds_oe", 32'(phy_rwds_oe), in_wd ? 32'd3 : 32'd0);
      if (o == 1) begin cap_ca0 = phy_dq_out; chk("ca0", phy_dq_out, e0); end
      if (o == 2) begin cap_ca1 = phy_dq_out; chk("ca1", phy_dq_out, e1); end
      if (in_wd) begin
        chk("wdata", phy_dq_out, wq[o - wd_lo]);
        chk("wmask", 32'(phy_rwds_out), 32'(mq[o - wd_lo]));
      end
      e_vld = 1'b0;
      rj = 0;
      if (!wr && !tmo)
        for (int j = 0; j <= len; j++)
          if (sq[j] == o - 1) begin e_vld = 1'b1; rj = j; end
      chk("rd_valid", 32'(rd_valid), 32'(e_vld));
      if (e_vld) chk("rd_data", rd_data, rq[rj]);
      chk("rd_last", 32'(rd_last), 32'(!wr && !tmo && o == sq[len] + 1));

      jv = 4'($urandom_range(0, 15));
      if (jv == 4'b0101) jv = 4'b0100;
      phy_rwds_in = jv;
      phy_dq_in   = $urandom;
      if (!wr && !tmo) begin
        for (int j = 0; j <= len; j++)
          if (sq[j] == o) begin phy_rwds_in = 4'b0101; phy_dq_in = rq[j]; end
        if (o == sq[len] + 1) phy_rwds_in = 4'b0101;
      end
      if (wr_ack) begin
        idx = (ack_n > 255) ? 255 : ack_n;
        wr_data = wq[idx];
        wr_mask = mq[idx];
        ack_n++;
      end
    end
    chk("wr_ack_cnt", 32'(ack_n), 32'(ack_exp));
  endtask

  task automatic fill_rd(input int len, input int lat, input bit tight);
    for (int j = 0; j <= len; j++) begin
      rq[j] = $urandom;
      if (j == 0) sq[j] = 5 + lat + (tight ? 0 : $urandom_range(0, 2));
      else        sq[j] = sq[j-1] + 1 + (tight ? 0 : $urandom_range(0, 2));
    end
  endtask

  initial begin
    int ty, len, lat;
    logic [N_CS-1:0] cs;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_write = 1'b0; cmd_reg = 1'b0; cmd_cs = '0; wr_data = '0; wr_mask = '0;
    cfg_lat = 4'd1; phy_dq_in = '0; phy_rwds_in = '0;

    repeat (3) @(negedge clk_1x);
    chk("rst_cs_n", 32'(phy_cs_n), 32'hF);
    chk("rst_ck_en", 32'(phy_ck_en), 32'd0);
    chk("rst_phy_rst_n", 32'(phy_rst_n), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_1x);
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_phy_rst_n", 32'(phy_rst_n), 32'd1);

    wq[0] = 32'hAABBCCDD; mq[0] = 4'b0000;
    wq[1] = 32'h11223344; mq[1] = 4'b0010;
    run_txn(1'b1, 1'b0, 32'h0000_1238, 1, 3, 4'b0001, 1'b0);
    chk("ca0_lanes", cap_ca0, 32'h4702_0020);
    chk("ca1_lanes", cap_ca1, 32'h0000_0000);

    wq[0] = 32'h0000_8F1F;
    run_txn(1'b1, 1'b1, 32'h0000_0800, 0, 5, 4'b0010, 1'b0);
    chk("reg_ca1_lanes", cap_ca1, 32'h8F1F_0000);

    fill_rd(3, 6, 1'b1);
    run_txn(1'b0, 1'b0, 32'h0001_0004, 3, 6, 4'b0100, 1'b0);

    for (int k = 0; k < 256; k++) begin wq[k] = $urandom; mq[k] = 4'($urandom); end
    run_txn(1'b1, 1'b0, 32'h00AB_CDE0, 255, 2, 4'b1000, 1'b0);

`ifdef HBUS_CTRL_TIMEOUT_EN
    run_txn(1'b0, 1'b0, 32'h0000_0100, 3, 4, 4'b0001, 1'b1);
`endif

    issue(1'b0, 1'b0, 32'h0000_0040, 3, 2, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_1x);
      cmd_valid = 1'b0;
      phy_rwds_in = 4'b0000;
    end
    chk("mid_pre_ck_en", 32'(phy_ck_en), 32'd3);
    rst_n = 1'b0;
    @(negedge clk_1x);
    chk("mid_cs_n", 32'(phy_cs_n), 32'hF);
    chk("mid_ck_en", 32'(phy_ck_en), 32'd0);
    chk("mid_phy_rst_n", 32'(phy_rst_n), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_1x);
      chk("mid_post_done", 32'(done), 32'd0);
      if (i == 0) chk("mid_post_ready", 32'(cmd_ready), 32'd1);
    end

    for (int t = 0; t < 20; t++) begin
      ty  = $urandom_range(0, 2);
      lat = $urandom_range(1, 15);
      cs  = N_CS'(1) << $urandom_range(0, N_CS - 1);
      for (int k = 0; k < 16; k++) begin wq[k] = $urandom; mq[k] = 4'($urandom); end
      if (ty == 0) begin
        len = $urandom_range(0, 7);
        run_txn(1'b1, 1'b0, $urandom & 32'hFFFF_FFFE, len, lat, cs, 1'b0);
      end else if (ty == 1) begin
        run_txn(1'b1, 1'b1, $urandom & 32'hFFFF_FFFE, 0, lat, cs, 1'b0);
      end else begin
        len = $urandom_range(0, 5);
        fill_rd(len, lat, 1'b0);
        run_txn(1'b0, ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFE, len, lat, cs, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hbus_ctrl.md
# hbus_ctrl

Transaction sequencer for the HyperBus PHY. It accepts one command at a time (memory or register space, read or write, 1..256 words) and produces the per-`clk_1x` PHY control: CK enable, DQ/RWDS drive and output-enable, and chip select. Read data is recovered from the RWDS strobe pattern. The block sits between the memory-controller front end and the HyperBus PHY, entirely in the `clk_1x` domain; each `clk_1x` cycle carries 4 bytes, which is 2 HyperBus CK cycles.

## Interface
Parameters:
- `N_CS`, 4: number of chip selects.
- `TCSH`, 2: minimum CS# high time between transactions, in `clk_1x` cycles (≥1).
- `RD_TIMEOUT`, 64: idle read cycles before abort (≥2).

Ports:
- `clk_1x`  in  1: controller/PHY 1x clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in/out  1: command handshake.
- `cmd_addr`  in  32: half-word address; bit 0 must be 0.
- `cmd_len`  in  8: word count minus 1.
- `cmd_write`  in  1: 1 = write.
- `cmd_reg`  in  1: 1 = register space.
- `cmd_cs`  in  N_CS: one-hot chip select.
- `wr_data`  in  32: write word; lane k = bits [8k+7:8k], lane 0 first on wire.
- `wr_mask`  in  4: per-lane byte mask (1 = masked).
- `wr_ack`  out  1: word sampled this edge.
- `rd_data`  out  32: read word.
- `rd_valid`  out  1: read word valid.
- `rd_last`  out  1: final read word.
- `done`  out  1: end-of-transaction pulse.
- `err`  out  1: read timeout, valid with `done`.
- `cfg_lat`  in  4: latency cycles (1..15), sampled at accept.
- `phy_ck_en`  out  2; `phy_dq_out`  out  32; `phy_dq_oe`  out  2; `phy_rwds_out`  out  4; `phy_rwds_oe`  out  2: PHY drive.
- `phy_dq_in`  in  32; `phy_rwds_in`  in  4: PHY capture.
- `phy_cs_n`  out  N_CS; `phy_rst_n`  out  1.

## Operation
- States: IDLE, CA0, CA1, LAT, WDATA, RDATA, RDRAIN, CSHI.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch the command and go to CA0.
- CA bits:
  - CA[47] = !`cmd_write`.
  - CA[46] = `cmd_reg`.
  - CA[45] = 1 (linear burst).
  - CA[44:16] = addr[31:3].
  - CA[15:3] = 0.
  - CA[2:0] = addr[2:0].
- CA0: lanes 0..3 = CA[47:16], MSB byte first.
- CA1:
  - Lanes 0,1 = CA[15:0].
  - For a register write, lanes 2,3 = `wr_data[15:0]` and `wr_ack` is pulsed; next state is CSHI.
  - Otherwise lanes 2,3 = 0 and next state is LAT.
- CA0/CA1 drive: `phy_ck_en`=11, `phy_dq_oe`=11, `phy_rwds_oe`=00, selected `phy_cs_n` bit=0.
- LAT:
  - Lasts `cfg_lat` cycles with `ck_en`=11 and DQ tri-stated.
  - Next state is WDATA or RDATA.
- WDATA (len+1 cycles):
  - `ck_en`=11, `dq_oe`=11, `rwds_oe`=11.
  - `phy_dq_out` = the word sampled on the previous `wr_ack` edge; `phy_rwds_out` = its mask.
  - `wr_ack` is high for len+1 consecutive cycles, starting in the last LAT cycle.
- RDATA (len+1 cycles): `ck_en`=11, DQ and RWDS tri-stated.
- RDRAIN: `ck_en`=00, CS held low until all words are received.
- Read capture (during LAT, RDATA, RDRAIN):
  - A cycle with `phy_rwds_in`==4'b0101 yields `rd_valid`=1 and `rd_data`=`phy_dq_in`, registered, one cycle later.
  - Any other pattern is ignored.
  - Words beyond len+1 are discarded.
  - `rd_last` accompanies word len+1.
- Completion:
  - The last read word, end of WDATA, or end of register-write CA1 enters CSHI with a `done` pulse.
- CSHI: all `cs_n`=1, `ck_en`=00, all OE=0 for `TCSH` cycles, then IDLE.
- `phy_rst_n`: registered copy of `rst_n`.

## Timing
- All outputs are registered.
- Reset values:
  - `phy_cs_n` all 1; `phy_rst_n`=0.
  - `ck_en`, `dq_oe`, `rwds_oe`=0; `dq_out`, `rwds_out`=0.
  - `cmd_ready`=0 (rises the first cycle after release).
  - `wr_ack`, `rd_valid`, `rd_last`, `done`, `err`=0.
- Command accepted at edge T:
  - CA0 at T+1, CA1 at T+2.
  - LAT at T+3..T+2+`cfg_lat`.
  - First data cycle at T+3+`cfg_lat`.
- Register write: `done` at T+3, `cmd_ready` at T+3+`TCSH`.
- `cmd_ready` is low from the accept edge until back in IDLE; there is no back-to-back command without CSHI.
- `cmd_len`=255: 256 data cycles; the word counter is 9 bits and has no wrap.
- Reset asserted mid-transaction: the next edge forces reset values, CS# deasserts immediately, and no `done` is issued.
- Stimulus outside the handshake: `wr_ack` is not back-pressured; the front end must present data on every `wr_ack`.

## Configuration
- `HBUS_CTRL_TIMEOUT_EN` defined:
  - A read idle counter is active in RDATA/RDRAIN and is cleared on each accepted word.
  - When it reaches `RD_TIMEOUT`: enter CSHI with `done`=1 and `err`=1; no `rd_last` is issued.
- Not defined:
  - No counter; RDRAIN waits indefinitely.
  - `err` is tied 0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `phy_cs_n`=4'hF, `ck_en`=0, `phy_rst_n`=0; `cmd_ready`=1 one cycle after release.
- Memory write: addr=0x0000_1238, len=1, `cfg_lat`=3, words 0xAABBCCDD/0x11223344, masks 0/4'b0010 → CA0 lanes=20,00,02,47; CA1 lanes=00,00; 3 LAT cycles; 2 WDATA cycles with `rwds_out`=0 then 0010; `done` 1 cycle after; cs_n high `TCSH` cycles.
- Register write: `cmd_reg`=1, addr=0x0000_0800, `wr_data`=0x8F1F → CA1 lanes 2,3=1F,8F; `done` at T+3; no LAT cycles.
- Read: len=3, `cfg_lat`=6, model returns 4 words with 2-cycle pipeline delay → 4 `rd_valid`, `rd_last` on 4th, `done` the cycle after the last word, `err`=0.
- Read timeout (macro on): model never toggles RWDS → `done`=`err`=1 exactly `RD_TIMEOUT` cycles after RDATA entry, CS released.
- Mid-read reset: assert `rst_n`=0 in RDATA → next edge cs_n=4'hF, `ck_en`=0, no `done`.
